// File: rtl/comparador_pkg.sv
// Shared types for the comparator family: relation selector and window FSM states.
package comparador_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10,
        CMP_NE = 2'b11
    } cmp_mode_e;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fsm_e;

endpackage

// File: rtl/comparador_rel.sv
// Combinational unsigned relation evaluator: compares a window against a fixed constant.
module comparador_rel
    import comparador_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] CONST = 4'b0101
) (
    input  logic [WIDTH-1:0] window,
    input  cmp_mode_e        mode,
    output logic             hit
);

    // Select the relation requested by mode
    always_comb begin
        hit = 1'b0;
        case (mode)
            CMP_EQ:  hit = (window == CONST);
            CMP_GT:  hit = (window >  CONST);
            CMP_LT:  hit = (window <  CONST);
            CMP_NE:  hit = (window != CONST);
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/comparador_serial_const.sv
// Serial sync-word detector: shifts a bit stream into a WIDTH window and pulses match
// whenever a completed window satisfies the selected relation against CONST.
module comparador_serial_const
    import comparador_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] CONST   = 4'b0101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [1:0]       cmp_mode,
    input  logic             clear,
    output logic             match,
    output logic             window_full,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W   = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [WIDTH-1:0]  sr_r;
    logic [WIDTH-1:0]  sr_shift_s;
    logic [WIDTH-1:0]  sr_next_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_inc_s;
    logic [FILL_W-1:0] fill_next_s;
    fsm_e              state_r;
    fsm_e              state_next_s;
    logic              match_r;
    logic              match_next_s;
    logic              window_full_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic              qualify_s;
    logic              hit_s;

    // Accept the incoming bit into the window and advance the saturating fill count
    always_comb begin
        sr_shift_s = sr_r;
        fill_inc_s = fill_r;
        if (in_valid) begin
            sr_shift_s = {sr_r[WIDTH-2:0], in_bit};
            if (fill_r != FILL_MAX) begin
                fill_inc_s = fill_r + FILL_W'(1);
            end else begin
                fill_inc_s = fill_r;
            end
        end else begin
            sr_shift_s = sr_r;
            fill_inc_s = fill_r;
        end
    end

    // Only an accepted bit that leaves the window full yields a fresh comparison
    assign qualify_s = in_valid && (fill_inc_s == FILL_MAX);

    comparador_rel #(
        .WIDTH (WIDTH),
        .CONST (CONST)
    ) u_rel (
        .window (sr_shift_s),
        .mode   (cmp_mode_e'(cmp_mode)),
        .hit    (hit_s)
    );

    // Next-state, match and counter logic; clear overrides everything including in_valid
    always_comb begin
        state_next_s = state_r;
        fill_next_s  = fill_inc_s;
        sr_next_s    = sr_shift_s;
        match_next_s = 1'b0;
        count_next_s = count_r;

        case (state_r)
            FILL:    state_next_s = (fill_inc_s == FILL_MAX) ? RUN : FILL;
            RUN:     state_next_s = RUN;
            default: state_next_s = FILL;
        endcase

        if (clear) begin
            state_next_s = FILL;
            fill_next_s  = '0;
            sr_next_s    = '0;
            match_next_s = 1'b0;
            count_next_s = '0;
        end else if (qualify_s && hit_s) begin
            match_next_s = 1'b1;
            if (count_r != CNT_MAX) begin
                count_next_s = count_r + CNT_W'(1);
            end else begin
                count_next_s = count_r;
            end
            // Non-overlapping mode discards the matched window and refills from scratch
            if (OVERLAP == 1'b0) begin
                state_next_s = FILL;
                fill_next_s  = '0;
            end else begin
                state_next_s = RUN;
            end
        end else begin
            match_next_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r          <= '0;
            fill_r        <= '0;
            state_r       <= FILL;
            match_r       <= 1'b0;
            window_full_r <= 1'b0;
            count_r       <= '0;
        end else begin
            sr_r          <= sr_next_s;
            fill_r        <= fill_next_s;
            state_r       <= state_next_s;
            match_r       <= match_next_s;
            window_full_r <= (state_next_s == RUN);
            count_r       <= count_next_s;
        end
    end

    assign match       = match_r;
    assign window_full = window_full_r;
    assign match_count = count_r;

endmodule

// File: tb/tb_comparador_serial_const.sv
// Scoreboard bench: three configurations share one stimulus stream and are checked
// against a bit-history reference model every cycle.
module tb_comparador_serial_const;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic [1:0] cmp_mode = 2'b00;
    logic       clear = 1'b0;

    logic       match_a, match_b, match_c;
    logic       full_a, full_b, full_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    comparador_serial_const #(.WIDTH(4), .CONST(4'b0101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .cmp_mode(cmp_mode),
        .clear(clear), .match(match_a), .window_full(full_a), .match_count(cnt_a));

    comparador_serial_const #(.WIDTH(4), .CONST(4'b0101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .cmp_mode(cmp_mode),
        .clear(clear), .match(match_b), .window_full(full_b), .match_count(cnt_b));

    comparador_serial_const #(.WIDTH(4), .CONST(4'b0101), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .cmp_mode(cmp_mode),
        .clear(clear), .match(match_c), .window_full(full_c), .match_count(cnt_c));

    // Reference model: per configuration, count of bits collected and last four bits as a number
    int m_fill [3];
    int m_win  [3];
    int m_cnt  [3];
    bit m_match[3];
    int ovl    [3] = '{1, 0, 1};
    int cmax   [3] = '{255, 255, 3};

    typedef struct {
        int       tag;
        logic [2:0] m;
        logic [2:0] f;
        int       c0;
        int       c1;
        int       c2;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_fill[i] = 0; m_win[i] = 0; m_cnt[i] = 0; m_match[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit v, input bit b, input int md, input bit clr);
        bit rel;
        for (int i = 0; i < 3; i++) begin
            m_match[i] = 1'b0;
            if (clr) begin
                m_fill[i] = 0; m_win[i] = 0; m_cnt[i] = 0;
            end else if (v) begin
                m_win[i] = (m_win[i] * 2 + int'(b)) % 16;
                if (m_fill[i] < 4) m_fill[i]++;
                if (m_fill[i] == 4) begin
                    case (md)
                        0:       rel = (m_win[i] == 5);
                        1:       rel = (m_win[i] > 5);
                        2:       rel = (m_win[i] < 5);
                        default: rel = (m_win[i] != 5);
                    endcase
                    if (rel) begin
                        m_match[i] = 1'b1;
                        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                        if (ovl[i] == 0) m_fill[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic push(input int tag);
        exp_t x;
        x.tag = tag;
        for (int i = 0; i < 3; i++) begin
            x.m[i] = m_match[i];
            x.f[i] = (m_fill[i] == 4);
        end
        x.c0 = m_cnt[0]; x.c1 = m_cnt[1]; x.c2 = m_cnt[2];
        sbq.push_back(x);
    endtask

    task automatic step(input bit v, input bit b, input logic [1:0] md, input bit clr);
        @(posedge clk); #1;
        in_valid = v; in_bit = b; cmp_mode = md; clear = clr;
        model_edge(v, b, int'(md), clr);
        push(cyc + 1);
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input logic [1:0] md);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], md, 1'b0);
    endtask

    // Asynchronous reset pulse placed between monitor sampling and the next edge
    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
        model_reset();
        model_edge(1'b0, 1'b0, 0, 1'b0);
        push(cyc + 1);
        #5 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Monitor: compare every output against the entry expected for this edge
    always begin
        @(posedge clk); #3;
        while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            e = sbq.pop_front();
            if (e.tag < cyc) begin
                check("stale_entry", 32'(e.tag), 32'(cyc));
            end else begin
                check("match_a", 32'(match_a), 32'(e.m[0]));
                check("match_b", 32'(match_b), 32'(e.m[1]));
                check("match_c", 32'(match_c), 32'(e.m[2]));
                check("full_a",  32'(full_a),  32'(e.f[0]));
                check("full_b",  32'(full_b),  32'(e.f[1]));
                check("full_c",  32'(full_c),  32'(e.f[2]));
                check("count_a", 32'(cnt_a),   32'(e.c0));
                check("count_b", 32'(cnt_b),   32'(e.c1));
                check("count_c", 32'(cnt_c),   32'(e.c2));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_match", 32'({match_a, match_b, match_c}), 32'd0);
        check("reset_full",  32'({full_a, full_b, full_c}), 32'd0);
        check("reset_count", 32'({cnt_a, cnt_b, cnt_c}), 32'd0);
        rst_n = 1'b1;

        // EQ 0101 then 01: overlapping configs match twice, non-overlapping once
        step(1'b0, 1'b0, 2'b00, 1'b1);
        feed(16'b0101, 4, 2'b00);
        feed(16'b01, 2, 2'b00);
        step(1'b0, 1'b0, 2'b00, 1'b0);

        // GT with an idle gap, then LT
        step(1'b0, 1'b0, 2'b01, 1'b1);
        feed(16'b01, 2, 2'b01);
        repeat (3) step(1'b0, 1'b0, 2'b01, 1'b0);
        feed(16'b10, 2, 2'b01);
        feed(16'b0011, 4, 2'b10);
        step(1'b0, 1'b0, 2'b10, 1'b0);

        // Saturation of the narrow counter
        step(1'b0, 1'b0, 2'b00, 1'b1);
        feed(16'b0101010101, 10, 2'b00);
        step(1'b0, 1'b0, 2'b00, 1'b0);

        // Reset mid-window, then clear together with a valid bit after a match
        step(1'b0, 1'b0, 2'b00, 1'b1);
        feed(16'b010, 3, 2'b00);
        do_reset();
        feed(16'b1, 1, 2'b00);
        repeat (2) step(1'b0, 1'b0, 2'b00, 1'b0);
        feed(16'b0101, 4, 2'b00);
        step(1'b1, 1'b1, 2'b00, 1'b1);
        repeat (2) step(1'b0, 1'b0, 2'b00, 1'b0);

        // Randomized traffic with mode changes, clears and occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);
            end
        end
        step(1'b0, 1'b0, 2'b00, 1'b0);

        repeat (3) @(posedge clk);
        #4;
        check("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
